tnoc_port_arbiter: RTL and testbench
====================================

Name: tnoc_port_arbiter

Overview:
- Arbitrator-side consumer of the per-virtual-channel port control bundle: request, grant, free, start_of_packet, end_of_packet.
- One instance per router output port. It collects the control signals of REQUESTERS input ports.
- Per virtual channel, it grants the output VC to exactly one requester and holds that grant for a whole packet (wormhole lock).
- Requester selection is round-robin; grant start is gated by downstream VC readiness.

Parameters:
- CONFIG, TNOC_DEFAULT_CONFIG: tnoc_config; CHANNELS = CONFIG.virtual_channels.
- REQUESTERS, 5: number of input ports competing for this output port.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_request  input  REQUESTERS*CHANNELS  request[r*CHANNELS+v]: requester r wants VC v.
- i_start_of_packet  input  REQUESTERS*CHANNELS  head flit present on r/v.
- i_end_of_packet  input  REQUESTERS*CHANNELS  tail flit present on r/v.
- i_free  input  REQUESTERS*CHANNELS  flit on r/v transferred this cycle.
- i_vc_ready  input  CHANNELS  downstream VC v can accept a new packet.
- o_grant  output  REQUESTERS*CHANNELS  registered per-VC one-hot grant.
- o_busy  output  CHANNELS  VC v is locked to a requester.
- o_grant_index  output  CHANNELS*clog2(REQUESTERS)  binary index of owner per VC; 0 when idle.

Behaviour:
- Reset (async, rst_n low): all o_grant, o_busy and o_grant_index are 0. All round-robin pointers are 0. All VC FSMs go to IDLE. Reset mid-packet drops the lock immediately; there is no recovery of partial packets.
- The VC FSMs are independent; each VC has states IDLE and BUSY.
- Eligibility: requester r is eligible for VC v when i_request[r][v] and i_start_of_packet[r][v] are both high. A request without start_of_packet is never granted.
- Arbitration for VC v happens when i_vc_ready[v] is high and either of these holds:
  - the VC is in IDLE, or
  - the VC is in BUSY and this is its release cycle.
- Round-robin arbitration: search starts at ptr[v] and wraps modulo REQUESTERS. The first eligible r wins.
- Winner update:
  - o_grant[r][v] = 1, o_grant_index[v] = r and o_busy[v] = 1 on the next rising edge (latency 1).
  - ptr[v] = (r+1) mod REQUESTERS, with wrap from REQUESTERS-1 to 0.
- BUSY: the grant is held regardless of i_request, i_vc_ready and other requesters.
- Release cycle: i_free[g][v] and i_end_of_packet[g][v] are both high from the owner g.
  - With no eligible winner, or i_vc_ready[v] low: grant, busy and index clear next cycle, and the FSM goes to IDLE.
  - With a winner: ownership transfers back-to-back with no idle cycle. The winner may be g itself only if g is the sole eligible requester.
- Single-flit packet (start and end asserted together) releases on its first i_free.
- i_free or i_end_of_packet from a non-owner is ignored.
- i_free without i_end_of_packet keeps BUSY.
- One requester may own several VCs simultaneously.
- o_grant is one-hot or zero per VC at all times. Assertion: two o_grant bits set for one VC is an error.
- All outputs come directly from flops; there is no combinational input-to-output path.

Decomposition:
- Shared package tnoc_router_pkg holds:
  - typedef tnoc_vc_state_e {IDLE, BUSY};
  - function tnoc_rr_select (one-hot select given request vector and pointer);
  - localparam width helper for clog2(REQUESTERS).
- Natural sub-module: tnoc_vc_arbiter. It is per-VC: FSM, pointer, grant register, index encode. It is instantiated CHANNELS times in a generate loop; the top block only slices and re-packs vectors.

Test Plan:
- Reset and idle check (REQUESTERS=5, CHANNELS=2): hold rst_n low with all requests high → all outputs 0. Release with no requests → outputs stay 0.
- Round-robin rotation on VC0:
  - Requesters 1 and 3 request with sop, ptr=0. Grant goes to r1 one cycle later, o_grant_index[0]=1.
  - Tail with free from r1 → r3 granted the very next cycle, o_busy[0] stays 1.
  - Tail from r3 with r1 requesting again → r1 granted.
- Packet lock: r2 owns VC1 across a 4-flit packet. Mid-packet r0 raises request+sop and r2 deasserts request → grant stays r2 until r2 free+eop, then r0 granted.
- vc_ready gating: r4 requests VC0 with i_vc_ready[0]=0 for 3 cycles → no grant. Ready rises → grant to r4 on the next cycle.
- Single-flit packets and independent VCs:
  - r0 sends sop+eop on VC0 while r0 sends a 3-flit packet on VC1 → both grants coexist.
  - VC0 releases after 1 free; VC1 releases after the 3rd free.
  - A free from non-owner r3 on VC1 is ignored.
- Reset mid-packet: rst_n pulsed low while VC0 and VC1 are BUSY → all outputs 0 asynchronously. After release, re-arbitration starts with ptr=0.

Source files
------------

// File: rtl/tnoc_router_pkg.sv
// Shared router definitions for the output-port arbiter.
//   tnoc_config          : router configuration record (virtual channel count).
//   TNOC_DEFAULT_CONFIG  : two virtual channels.
//   tnoc_vc_state_e      : per-VC lock state (IDLE / BUSY).
//   tnoc_index_width()   : bits needed to hold a requester index (min 1).
//   tnoc_rr_select()     : round-robin one-hot pick starting at a pointer.
package tnoc_router_pkg;

  typedef struct packed {
    int virtual_channels;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 2};

  localparam int TNOC_DEFAULT_REQUESTERS = 5;

  // Widest request vector tnoc_rr_select can handle; callers zero-extend.
  localparam int TNOC_MAX_REQUESTERS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tnoc_vc_state_e;

  function automatic int tnoc_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scan n requesters starting at ptr, wrapping back to 0 after n-1, and
  // return a one-hot vector marking the first requester found (or zero).
  // ptr must be below n, so ptr+i never reaches 2n and a single
  // subtraction performs the wrap.
  function automatic logic [TNOC_MAX_REQUESTERS-1:0] tnoc_rr_select(
    input logic [TNOC_MAX_REQUESTERS-1:0] request,
    input int unsigned                    ptr,
    input int unsigned                    n
  );
    logic [TNOC_MAX_REQUESTERS-1:0] result;
    logic                           found;
    int unsigned                    idx;
    result = '0;
    found  = 1'b0;
    for (int i = 0; i < TNOC_MAX_REQUESTERS; i++) begin
      if (i < int'(n)) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && request[idx[4:0]]) begin
          result[idx[4:0]] = 1'b1;
          found            = 1'b1;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/tnoc_vc_arbiter.sv
// Wormhole arbiter for one virtual channel of one output port.
//   request/start_of_packet/end_of_packet/free : per-requester control for this VC.
//   vc_ready    : downstream VC can accept a new packet.
//   grant       : registered one-hot owner of this VC.
//   busy        : VC is locked to a requester.
//   grant_index : binary owner index, 0 when idle.
// A requester is eligible only while presenting a head flit. Once granted,
// the lock is held until the owner transfers its tail flit; a new owner can
// take over in that same release cycle so the VC never idles between packets.
module tnoc_vc_arbiter
  import tnoc_router_pkg::*;
#(
  parameter int REQUESTERS  = TNOC_DEFAULT_REQUESTERS,
  parameter int INDEX_WIDTH = tnoc_index_width(REQUESTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REQUESTERS-1:0]  request,
  input  logic [REQUESTERS-1:0]  start_of_packet,
  input  logic [REQUESTERS-1:0]  end_of_packet,
  input  logic [REQUESTERS-1:0]  free,
  input  logic                   vc_ready,
  output logic [REQUESTERS-1:0]  grant,
  output logic                   busy,
  output logic [INDEX_WIDTH-1:0] grant_index
);

  tnoc_vc_state_e state;
  logic [INDEX_WIDTH-1:0] ptr;

  logic [REQUESTERS-1:0]          eligible;
  logic [TNOC_MAX_REQUESTERS-1:0] eligible_wide;
  logic [TNOC_MAX_REQUESTERS-1:0] select_wide;
  logic [REQUESTERS-1:0]          select;
  logic [INDEX_WIDTH-1:0]         winner;
  logic [INDEX_WIDTH-1:0]         ptr_next;
  logic                           has_winner;
  logic                           release_now;
  logic                           arbitrate;

  assign eligible = request & start_of_packet;

  // Only the current owner's tail transfer can end the lock; free/eop from
  // any other requester are never looked at.
  assign release_now = (state == BUSY) && free[grant_index] && end_of_packet[grant_index];
  assign arbitrate   = vc_ready && ((state == IDLE) || release_now);

  // NOTE: every signal written in an always_comb gets a default value first,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    eligible_wide                 = '0;
    eligible_wide[REQUESTERS-1:0] = eligible;
  end

  // The pointer sits one past the previous winner, so that winner is searched
  // last and can only win again when nobody else is eligible.
  assign select_wide = tnoc_rr_select(eligible_wide, 32'(ptr), REQUESTERS);
  assign select      = select_wide[REQUESTERS-1:0];
  assign has_winner  = |select;

  always_comb begin
    winner = '0;
    for (int r = 0; r < REQUESTERS; r++) begin
      if (select[r]) winner = INDEX_WIDTH'(r);
    end
  end

  assign ptr_next = (winner == INDEX_WIDTH'(REQUESTERS - 1)) ? '0 : winner + INDEX_WIDTH'(1);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      grant_index <= '0;
    end else begin
      if (arbitrate && has_winner) begin
        state       <= BUSY;
        ptr         <= ptr_next;
        grant       <= select;
        busy        <= 1'b1;
        grant_index <= winner;
      end else if (release_now) begin
        // Tail left with no successor (or downstream not ready): drop the lock.
        state       <= IDLE;
        grant       <= '0;
        busy        <= 1'b0;
        grant_index <= '0;
      end
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant))
    else $error("tnoc_vc_arbiter: more than one grant bit set");

endmodule

// File: rtl/tnoc_port_arbiter.sv
// Output-port arbiter: one independent wormhole arbiter per virtual channel.
//   i_request/i_start_of_packet/i_end_of_packet/i_free : bit r*CHANNELS+v is requester r, VC v.
//   i_vc_ready    : per-VC downstream readiness for a new packet.
//   o_grant       : bit r*CHANNELS+v set while requester r owns VC v (one-hot per VC).
//   o_busy        : per-VC lock flag.
//   o_grant_index : per-VC owner index, field v at [v*INDEX_WIDTH +: INDEX_WIDTH].
// This level only regroups the requester-major buses into per-VC vectors;
// all outputs are driven straight from the per-VC flops.
module tnoc_port_arbiter
  import tnoc_router_pkg::*;
#(
  parameter tnoc_config CONFIG     = TNOC_DEFAULT_CONFIG,
  parameter int         REQUESTERS = TNOC_DEFAULT_REQUESTERS,
  localparam int        CHANNELS    = CONFIG.virtual_channels,
  localparam int        INDEX_WIDTH = tnoc_index_width(REQUESTERS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [REQUESTERS*CHANNELS-1:0]  i_request,
  input  logic [REQUESTERS*CHANNELS-1:0]  i_start_of_packet,
  input  logic [REQUESTERS*CHANNELS-1:0]  i_end_of_packet,
  input  logic [REQUESTERS*CHANNELS-1:0]  i_free,
  input  logic [CHANNELS-1:0]             i_vc_ready,
  output logic [REQUESTERS*CHANNELS-1:0]  o_grant,
  output logic [CHANNELS-1:0]             o_busy,
  output logic [CHANNELS*INDEX_WIDTH-1:0] o_grant_index
);

  for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
    logic [REQUESTERS-1:0] request_v;
    logic [REQUESTERS-1:0] sop_v;
    logic [REQUESTERS-1:0] eop_v;
    logic [REQUESTERS-1:0] free_v;
    logic [REQUESTERS-1:0] grant_v;

    for (genvar r = 0; r < REQUESTERS; r++) begin : g_req
      assign request_v[r]             = i_request[r*CHANNELS+v];
      assign sop_v[r]                 = i_start_of_packet[r*CHANNELS+v];
      assign eop_v[r]                 = i_end_of_packet[r*CHANNELS+v];
      assign free_v[r]                = i_free[r*CHANNELS+v];
      assign o_grant[r*CHANNELS+v]    = grant_v[r];
    end

    tnoc_vc_arbiter #(
      .REQUESTERS  (REQUESTERS),
      .INDEX_WIDTH (INDEX_WIDTH)
    ) u_vc_arbiter (
      .clk             (clk),
      .rst_n           (rst_n),
      .request         (request_v),
      .start_of_packet (sop_v),
      .end_of_packet   (eop_v),
      .free            (free_v),
      .vc_ready        (i_vc_ready[v]),
      .grant           (grant_v),
      .busy            (o_busy[v]),
      .grant_index     (o_grant_index[v*INDEX_WIDTH +: INDEX_WIDTH])
    );
  end

endmodule

// File: tb/tb_tnoc_port_arbiter.sv
// Self-checking bench for tnoc_port_arbiter (5 requesters, 2 VCs).
// A behavioural model tracks, per VC, the owning requester (-1 when idle)
// and the round-robin start position; a compare process checks every DUT
// output against it on each falling edge. Directed scenarios add literal
// expectations, then a randomized phase stresses the arbitration rules.
module tb_tnoc_port_arbiter;
  import tnoc_router_pkg::*;

  localparam int R  = 5;
  localparam int C  = 2;
  localparam int IW = tnoc_index_width(R);
  localparam int N  = R * C;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   sop = '0;
  logic [N-1:0]   eop = '0;
  logic [N-1:0]   free = '0;
  logic [C-1:0]   ready = '1;
  logic [N-1:0]   o_grant;
  logic [C-1:0]   o_busy;
  logic [C*IW-1:0] o_grant_index;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  tnoc_port_arbiter #(
    .CONFIG     (TNOC_DEFAULT_CONFIG),
    .REQUESTERS (R)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_request         (req),
    .i_start_of_packet (sop),
    .i_end_of_packet   (eop),
    .i_free            (free),
    .i_vc_ready        (ready),
    .o_grant           (o_grant),
    .o_busy            (o_busy),
    .o_grant_index     (o_grant_index)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int owner [C];
  int rr_start [C];

  always @(posedge clk or negedge rst_n) begin : model
    bit rel;
    int w;
    int r;
    if (!rst_n) begin
      for (int v = 0; v < C; v++) begin
        owner[v]    = -1;
        rr_start[v] = 0;
      end
    end else begin
      for (int v = 0; v < C; v++) begin
        rel = (owner[v] >= 0) && free[owner[v]*C+v] && eop[owner[v]*C+v];
        if (owner[v] < 0 || rel) begin
          w = -1;
          if (ready[v]) begin
            for (int i = 0; i < R; i++) begin
              r = (rr_start[v] + i) % R;
              if (w < 0 && req[r*C+v] && sop[r*C+v]) w = r;
            end
          end
          if (w >= 0) begin
            owner[v]    = w;
            rr_start[v] = (w + 1) % R;
          end else begin
            owner[v] = -1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0]    exp_grant;
    logic [C-1:0]    exp_busy;
    logic [C*IW-1:0] exp_index;
    if (cmp_en) begin
      exp_grant = '0;
      exp_busy  = '0;
      exp_index = '0;
      for (int v = 0; v < C; v++) begin
        if (owner[v] >= 0) begin
          exp_grant[owner[v]*C+v]  = 1'b1;
          exp_busy[v]              = 1'b1;
          exp_index[v*IW +: IW]    = IW'(owner[v]);
        end
      end
      check("grant", 32'(o_grant), 32'(exp_grant));
      check("busy", 32'(o_busy), 32'(exp_busy));
      check("grant_index", 32'(o_grant_index), 32'(exp_index));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs set before step() are sampled at the next rising edge; step()
  // returns just after the following falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req   = '0;
    sop   = '0;
    eop   = '0;
    free  = '0;
    ready = '1;
  endtask

  task automatic drive(input int r, input int v, input bit rq, input bit s, input bit e, input bit f);
    req[r*C+v]  = rq;
    sop[r*C+v]  = s;
    eop[r*C+v]  = e;
    free[r*C+v] = f;
  endtask

  function automatic logic [IW-1:0] idx_of(input int v);
    return o_grant_index[v*IW +: IW];
  endfunction

  initial begin
    // Reset with every request high: outputs must be zero.
    #1;
    rst_n = 1'b0;
    req   = '1;
    sop   = '1;
    cmp_en = 1'b1;
    repeat (3) step();
    check("reset_grant", 32'(o_grant), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    clear_inputs();
    rst_n = 1'b1;
    step();
    step();
    check("idle_grant", 32'(o_grant), 32'd0);
    check("idle_index", 32'(o_grant_index), 32'd0);

    // Round-robin rotation on VC0.
    drive(1, 0, 1, 1, 0, 0);
    drive(3, 0, 1, 1, 0, 0);
    step();
    check("rr_first_idx", 32'(idx_of(0)), 32'd1);
    check("rr_first_bit", 32'(o_grant[1*C+0]), 32'd1);
    drive(1, 0, 0, 0, 1, 1);
    step();
    check("rr_handoff_idx", 32'(idx_of(0)), 32'd3);
    check("rr_handoff_busy", 32'(o_busy[0]), 32'd1);
    drive(3, 0, 0, 0, 1, 1);
    drive(1, 0, 1, 1, 0, 0);
    step();
    check("rr_back_idx", 32'(idx_of(0)), 32'd1);
    drive(3, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1);
    step();
    check("rr_release_busy", 32'(o_busy[0]), 32'd0);
    clear_inputs();

    // Packet lock: r2 holds VC1 across a 4-flit packet.
    drive(2, 1, 1, 1, 0, 0);
    step();
    check("lock_grant_idx", 32'(idx_of(1)), 32'd2);
    drive(2, 1, 1, 0, 0, 1);
    step();
    drive(0, 1, 1, 1, 0, 0);
    drive(2, 1, 0, 0, 0, 1);
    step();
    check("lock_hold_idx", 32'(idx_of(1)), 32'd2);
    step();
    check("lock_hold_idx2", 32'(idx_of(1)), 32'd2);
    drive(2, 1, 0, 0, 1, 1);
    step();
    check("lock_next_idx", 32'(idx_of(1)), 32'd0);
    check("lock_next_bit", 32'(o_grant[0*C+1]), 32'd1);
    clear_inputs();
    drive(0, 1, 0, 0, 1, 1);
    step();
    check("lock_release", 32'(o_busy[1]), 32'd0);
    clear_inputs();

    // vc_ready gating.
    ready[0] = 1'b0;
    drive(4, 0, 1, 1, 0, 0);
    repeat (3) begin
      step();
      check("gate_no_grant", 32'(o_busy[0]), 32'd0);
    end
    ready[0] = 1'b1;
    step();
    check("gate_grant_idx", 32'(idx_of(0)), 32'd4);
    clear_inputs();
    drive(4, 0, 0, 0, 1, 1);
    step();
    clear_inputs();

    // Single-flit on VC0 and 3-flit on VC1, both from r0.
    drive(0, 0, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 0, 0);
    step();
    check("multi_vc_grant", 32'(o_grant), 32'h003);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0, 1);
    drive(3, 1, 0, 0, 1, 1);
    step();
    check("single_flit_free", 32'(o_busy), 32'b10);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("vc1_after_2nd", 32'(o_busy[1]), 32'd1);
    drive(3, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 1);
    step();
    check("vc1_after_3rd", 32'(o_busy[1]), 32'd0);
    clear_inputs();

    // Reset in the middle of packets on both VCs.
    drive(2, 0, 1, 1, 0, 0);
    drive(3, 1, 1, 1, 0, 0);
    step();
    check("pre_reset_busy", 32'(o_busy), 32'b11);
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_grant", 32'(o_grant), 32'd0);
    check("async_reset_busy", 32'(o_busy), 32'd0);
    check("async_reset_index", 32'(o_grant_index), 32'd0);
    step();
    rst_n = 1'b1;
    drive(1, 0, 1, 1, 0, 0);
    drive(3, 0, 1, 1, 0, 0);
    step();
    check("post_reset_ptr0", 32'(idx_of(0)), 32'd1);
    clear_inputs();

    // Randomized phase.
    for (int n = 0; n < 2000; n++) begin
      req   = N'($urandom);
      sop   = N'($urandom);
      eop   = N'($urandom);
      free  = N'($urandom);
      for (int v = 0; v < C; v++) ready[v] = ($urandom_range(0, 3) != 0);
      step();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
